// File: rtl/fifo_async_1clk_pkg.sv
// Shared constants and the Gray-encode helper for the single-clock dual-pointer FIFO.
package fifo_async_1clk_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Callers zero-extend their pointer in and truncate the result back to pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_async_1clk_sync2.sv
// Parameterised-width two-flop synchronizer with synchronous active-high reset.
module fifo_async_1clk_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make this a true two-stage shift; blocking would collapse it to one flop.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fifo_async_1clk.sv
// Circular-buffer FIFO using async-FIFO pointer structure (Gray pointers, 2-flop syncs) on one clock.
module fifo_async_1clk
  import fifo_async_1clk_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW    = ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [PW-1:0]         wbin_q,  wbin_d;
  logic [PW-1:0]         rbin_q,  rbin_d;
  logic [PW-1:0]         wgray_q, wgray_d;
  logic [PW-1:0]         rgray_q, rgray_d;
  logic [DATA_WIDTH-1:0] dout_q,  dout_d;
  logic [PW-1:0]         wq2, rq2;
  logic                  wr_fire, rd_fire;

  fifo_async_1clk_sync2 #(.WIDTH(PW)) u_sync_w2r (
    .clk   (clk),
    .reset (reset),
    .d     (wgray_q),
    .q     (wq2)
  );

  fifo_async_1clk_sync2 #(.WIDTH(PW)) u_sync_r2w (
    .clk   (clk),
    .reset (reset),
    .d     (rgray_q),
    .q     (rq2)
  );

  // Each side judges itself against a lagging view of the other, so flags err toward full/empty.
  assign empty = (rgray_q == wq2);
  assign full  = (wgray_q == {~rq2[AW:AW-1], rq2[AW-2:0]});

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wbin_d  = wbin_q;
    rbin_d  = rbin_q;
    dout_d  = dout_q;
    wr_fire = wr_en && !full;
    rd_fire = rd_en && !empty;
    if (wr_fire) wbin_d = wbin_q + PW'(1);
    if (rd_fire) begin
      rbin_d = rbin_q + PW'(1);
      dout_d = mem[rbin_q[AW-1:0]];
    end
    // Gray copies are taken from the next binary value so own-side flags update at the same edge.
    wgray_d = PW'(bin2gray(32'(wbin_d)));
    rgray_d = PW'(bin2gray(32'(rbin_d)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbin_q  <= '0;
      rbin_q  <= '0;
      wgray_q <= '0;
      rgray_q <= '0;
      dout_q  <= '0;
    end else begin
      wbin_q  <= wbin_d;
      rbin_q  <= rbin_d;
      wgray_q <= wgray_d;
      rgray_q <= rgray_d;
      dout_q  <= dout_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wbin_q[AW-1:0]] <= din;
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_fifo_async_1clk.sv
// Self-checking bench for fifo_async_1clk: vector table for basic traffic, directed sequences for corners.
module tb_fifo_async_1clk;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full, empty;

  int checks   = 0;
  int failures = 0;

  fifo_async_1clk #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive for one clock, then sample 1 time unit after the edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;

    // Test 1/2 vector table: empty falls after the 3rd write edge, dout follows reads.
    vecs[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h24, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h63, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h24};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h81};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h09};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h63};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h63};

    repeat (2) @(posedge clk);
    #1;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full",  32'(full),  32'd0);
    check("reset_dout",  32'(dout),  32'h00);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_full",  i), 32'(full),  32'(vecs[i].exp_full));
      check($sformatf("vec%0d_dout",  i), 32'(dout),  32'(vecs[i].exp_dout));
    end

    // Test 3: fill to 16, full right after the 16th, 17th write dropped, full falls 2 edges after first read.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      if (i == 14) check("fill15_full", 32'(full), 32'd0);
    end
    check("fill16_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b0, 8'hAA);
    check("overflow_full", 32'(full), 32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d_dout", i), 32'(dout), 32'(i));
      if (i < 2)  check($sformatf("drain%0d_full_lag", i), 32'(full), 32'd1);
      if (i == 2) check("drain2_full_clear", 32'(full), 32'd0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, 8'h00);
    check("underflow_dout", 32'(dout), 32'h0F);
    check("underflow_empty", 32'(empty), 32'd1);

    // Test 4: 40 words in batches of 8, pointers cross the wrap bit.
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h10 + b * 8 + i));
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
        cycle(1'b0, 1'b1, 8'h00);
        check($sformatf("wrap_b%0d_i%0d_dout", b, i), 32'(dout), 32'(8'h10 + b * 8 + i));
      end
      check($sformatf("wrap_b%0d_empty", b), 32'(empty), 32'd1);
    end

    // Test 5: simultaneous read/write at occupancy 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, 8'(8'h35 + k));
      check($sformatf("simul%0d_dout", k),  32'(dout),  32'(8'h30 + k));
      check($sformatf("simul%0d_empty", k), 32'(empty), 32'd0);
      check($sformatf("simul%0d_full", k),  32'(full),  32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check($sformatf("simul_tail%0d_dout", i), 32'(dout), 32'(8'h3A + i));
    end
    check("simul_tail_empty", 32'(empty), 32'd1);

    // Test 6: reset mid-operation discards 7 stored words.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("pre_reset_empty", 32'(empty), 32'd0);
    reset = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    check("midreset_empty", 32'(empty), 32'd1);
    check("midreset_full",  32'(full),  32'd0);
    check("midreset_dout",  32'(dout),  32'h00);
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    check("post_reset_dout",  32'(dout),  32'h5A);
    check("post_reset_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
